// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads one byte per instruction from
// the RAM port, and hands it to decode over a valid/ready handshake.
//
// Ports:
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   ram_read_en     read strobe to the RAM (combinational)
//   ram_address     RAM address, always equal to pc
//   ram_read_data   RAM read data, one cycle after ram_read_en
//   ram_busy        execute stage owns the RAM port this cycle
//   halt            block new fetches
//   jump_en         load pc from jump_addr and flush the stage
//   jump_addr       jump target
//   instr           fetched instruction byte
//   instr_pc        address that instr was fetched from
//   instr_valid     instr/instr_pc valid for decode
//   instr_ready     decode accepts the instruction
//   pc              current program counter

module fetch_unit #(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              ram_read_en,
    output logic [ADDR_W-1:0] ram_address,
    input  logic [DATA_W-1:0] ram_read_data,
    input  logic              ram_busy,
    input  logic              halt,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] pc
);

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        RESP = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    state_t            state;
    logic [ADDR_W-1:0] issued_pc;
    logic              in_req;
    logic              handshake;

    assign in_req    = (state == REQ);
    assign handshake = instr_valid && instr_ready;

    // Gated by rst_n so the RAM never sees a strobe while held in reset.
    assign ram_read_en = rst_n && in_req && !ram_busy
                      && !halt && !jump_en;
    assign ram_address = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= REQ;
            pc          <= PC_RST;
            issued_pc   <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else if (jump_en) begin
            // Flush: any read in flight is dropped, a pending
            // instruction is withdrawn (or was just consumed).
            state       <= REQ;
            pc          <= jump_addr;
            instr_valid <= 1'b0;
        end else begin
            unique case (state)
                REQ: begin
                    if (ram_read_en) begin
                        issued_pc <= pc;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    // Data was registered by the RAM on the issuing edge,
                    // so ram_busy cannot disturb this capture.
                    instr       <= ram_read_data;
                    instr_pc    <= issued_pc;
                    instr_valid <= 1'b1;
                    pc          <= pc + PC_ONE;
                    state       <= HOLD;
                end
                HOLD: begin
                    if (handshake) begin
                        instr_valid <= 1'b0;
                        state       <= REQ;
                    end
                end
                default: begin
                    state <= REQ;
                end
            endcase
        end
    end

endmodule
